vga_sync_receiver: RTL and testbench



---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_sync_edge.sv | 33 +++
 rtl/vga_sync_receiver.sv | 135 +++++++++++++
 tb/tb_vga_sync_receiver.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: VGA timing defaults shared with the display generator, receiver FSM states,
// RGB packing widths and CRC-16-CCITT constants.
package vga_pkg;
   localparam int HPIXELS     = 800;
   localparam int VLINES      = 431;
   localparam int HPULSE      = 96;
   localparam int VPULSE      = 2;
   localparam int HBP         = 144;
   localparam int HFP         = 784;
   localparam int VBP         = 31;
   localparam int VFP         = 391;
   localparam int LOCK_FRAMES = 2;
   localparam int CW          = 10;
   localparam int RW          = 3;
   localparam int GW          = 3;
   localparam int BW          = 2;
   localparam int PW          = RW + GW + BW;
   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   typedef enum logic [1:0] {SEARCH, TRAIN, LOCKED} state_t;
   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {d, 8'h00};
      for (int i = 0; i < 8; i++) r = r[15] ? {r[14:0], 1'b0} ^ CRC_POLY : {r[14:0], 1'b0};
      return r;
   endfunction
endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: registers one sync input, flags fall/rise and counts ticks since the last fall.
module vga_sync_edge
   import vga_pkg::*;
#(
   parameter int W = CW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_sync,
   input  logic         i_tick,
   output logic         o_fall,
   output logic         o_rise,
   output logic [W-1:0] o_cnt,
   output logic [W-1:0] o_cnt_nxt
);
   logic r_cur, r_prev;
   logic [W-1:0] r_cnt;
   always_ff @(posedge clk)
      if (rst) begin
         r_cur  <= 1'b1;
         r_prev <= 1'b1;
         r_cnt  <= '0;
      end else begin
         r_cur  <= i_sync;
         r_prev <= r_cur;
         r_cnt  <= o_cnt_nxt;
      end
   assign o_fall    = r_prev & ~r_cur;
   assign o_rise    = ~r_prev & r_cur;
   assign o_cnt     = r_cnt;
   // o_cnt_nxt is aligned with the registered sample, o_cnt with the one before it
   assign o_cnt_nxt = o_fall ? '0 : (i_tick && ~&r_cnt) ? r_cnt + 1'b1 : r_cnt;
endmodule

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers pixel position/colour from a VGA sync stream and tracks timing lock.
// Defining VGA_RX_CRC_EN adds a per-frame CRC-16-CCITT of the active pixels.
module vga_sync_receiver #(
   parameter int HPIXELS     = vga_pkg::HPIXELS,
   parameter int VLINES      = vga_pkg::VLINES,
   parameter int HPULSE      = vga_pkg::HPULSE,
   parameter int VPULSE      = vga_pkg::VPULSE,
   parameter int HBP         = vga_pkg::HBP,
   parameter int HFP         = vga_pkg::HFP,
   parameter int VBP         = vga_pkg::VBP,
   parameter int VFP         = vga_pkg::VFP,
   parameter int LOCK_FRAMES = vga_pkg::LOCK_FRAMES
) (
   input  logic        dclk,
   input  logic        rst,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [2:0]  red,
   input  logic [2:0]  green,
   input  logic [2:0]  blue,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [7:0]  pix_rgb,
   output logic        pix_valid,
   output logic        frame_start,
   output logic        locked,
   output logic        err_hline,
   output logic        err_vframe,
   output logic [7:0]  err_count
`ifdef VGA_RX_CRC_EN
   ,
   output logic [15:0] frame_crc,
   output logic        frame_crc_valid
`endif
);
   import vga_pkg::*;
   localparam logic [CW-1:0] H_END = CW'(HPIXELS - 1);
   localparam logic [CW-1:0] H_PW  = CW'(HPULSE - 1);
   localparam logic [CW-1:0] V_END = CW'(VLINES - 1);
   localparam logic [CW-1:0] V_PW  = CW'(VPULSE - 1);
   localparam logic [CW-1:0] H_BP  = CW'(HBP);
   localparam logic [CW-1:0] H_FP  = CW'(HFP);
   localparam logic [CW-1:0] V_BP  = CW'(VBP);
   localparam logic [CW-1:0] V_FP  = CW'(VFP);
   localparam logic [3:0] GOOD_LOCK = 4'(LOCK_FRAMES);
   logic w_hfall, w_hrise, w_vfall, w_vrise, w_chk, w_err_h, w_err_v, w_err, w_act;
   logic [CW-1:0] w_hc, w_hcq, w_vc, w_vcq;
   logic [PW-1:0] r_rgb;
   logic r_hchk, r_ferr;
   logic [3:0] r_good, w_good;
   state_t r_state, w_state;
   logic w_unused_blue;
   assign w_unused_blue = blue[2];
   vga_sync_edge u_h (
      .clk(dclk), .rst(rst), .i_sync(hsync), .i_tick(1'b1),
      .o_fall(w_hfall), .o_rise(w_hrise), .o_cnt(w_hcq), .o_cnt_nxt(w_hc)
   );
   vga_sync_edge u_v (
      .clk(dclk), .rst(rst), .i_sync(vsync), .i_tick(w_hfall),
      .o_fall(w_vfall), .o_rise(w_vrise), .o_cnt(w_vcq), .o_cnt_nxt(w_vc)
   );
   // no timing checks while searching; line checks also wait for one hsync fall after it
   assign w_chk   = r_state != SEARCH;
   assign w_err_h = w_chk && r_hchk && ((w_hfall && w_hcq != H_END) || (w_hrise && w_hcq != H_PW));
   assign w_err_v = w_chk && ((w_vfall && (!w_hfall || w_vcq != V_END)) || (w_vrise && w_vcq != V_PW));
   assign w_err   = w_err_h | w_err_v;
   assign w_act   = r_state == LOCKED && w_hc >= H_BP && w_hc < H_FP && w_vc >= V_BP && w_vc < V_FP;
   always_comb begin
      w_state = r_state;
      w_good  = r_good;
      case (r_state)
         SEARCH: if (w_vfall) begin
            w_state = TRAIN;
            w_good  = '0;
         end
         TRAIN: if (w_vfall) begin
            w_good = (r_ferr || w_err) ? '0 : r_good + 1'b1;
            if (w_good == GOOD_LOCK) begin
               w_state = LOCKED;
               w_good  = '0;
            end
         end
         LOCKED: if (w_err) begin
            w_state = TRAIN;
            w_good  = '0;
         end
         default: w_state = SEARCH;
      endcase
   end
   always_ff @(posedge dclk)
      if (rst) begin
         r_state     <= SEARCH;
         r_good      <= '0;
         r_hchk      <= 1'b0;
         r_ferr      <= 1'b0;
         r_rgb       <= '0;
         locked      <= 1'b0;
         frame_start <= 1'b0;
         err_hline   <= 1'b0;
         err_vframe  <= 1'b0;
         err_count   <= '0;
         pix_valid   <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         pix_rgb     <= '0;
      end else begin
         r_state     <= w_state;
         r_good      <= w_good;
         r_hchk      <= w_chk && (r_hchk || w_hfall);
         r_ferr      <= !w_vfall && (r_ferr || w_err);
         r_rgb       <= {red, green, blue[BW-1:0]};
         locked      <= r_state == LOCKED;
         frame_start <= w_vfall;
         err_hline   <= w_err_h;
         err_vframe  <= w_err_v;
         err_count   <= (w_err && ~&err_count) ? err_count + 8'd1 : err_count;
         pix_valid   <= w_act;
         pix_x       <= w_act ? w_hc - H_BP : '0;
         pix_y       <= w_act ? w_vc - V_BP : '0;
         pix_rgb     <= w_act ? r_rgb : '0;
      end
`ifdef VGA_RX_CRC_EN
   logic [15:0] r_crc;
   always_ff @(posedge dclk)
      if (rst) begin
         r_crc           <= CRC_INIT;
         frame_crc       <= '0;
         frame_crc_valid <= 1'b0;
      end else begin
         frame_crc_valid <= frame_start && locked;
         if (frame_start && locked) frame_crc <= r_crc;
         r_crc <= frame_start ? CRC_INIT : pix_valid ? crc16_byte(r_crc, pix_rgb) : r_crc;
      end
`endif
endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: frame-level directed vectors for vga_sync_receiver on reduced timing.
// Exercises the VGA_RX_CRC_EN ports when that macro is defined.
module tb_vga_sync_receiver;
   localparam int HP = 40, VL = 12, HW = 6, VW = 2, HB = 10, HF = 34, VB = 3, VF = 10;
   logic dclk, rst, hsync, vsync;
   logic [2:0] red, green, blue;
   logic [9:0] pix_x, pix_y;
   logic [7:0] pix_rgb, err_count;
   logic pix_valid, frame_start, locked, err_hline, err_vframe;
`ifdef VGA_RX_CRC_EN
   logic [15:0] frame_crc;
   logic frame_crc_valid;
`endif
   vga_sync_receiver #(
      .HPIXELS(HP), .VLINES(VL), .HPULSE(HW), .VPULSE(VW),
      .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF), .LOCK_FRAMES(2)
   ) dut (
      .dclk(dclk), .rst(rst), .hsync(hsync), .vsync(vsync),
      .red(red), .green(green), .blue(blue),
      .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .pix_valid(pix_valid),
      .frame_start(frame_start), .locked(locked),
      .err_hline(err_hline), .err_vframe(err_vframe), .err_count(err_count)
`ifdef VGA_RX_CRC_EN
      ,
      .frame_crc(frame_crc), .frame_crc_valid(frame_crc_valid)
`endif
   );
   initial dclk = 1'b0;
   always #5 dclk = ~dclk;
   typedef struct {
      int lines;
      int short_ln;
      int narrow_ln;
      int rst_ln;
      int pmode;
      int eh;
      int ev;
      int crcv;
      int lock_end;
      int ecnt;
   } frame_t;
   frame_t tbl[17];
   int checks = 0, errors = 0;
   int n = 0, pmode = 0, pix_bad, n_eh, n_ev, n_fs, n_crcv, first_valid, mark, last_fs, last_rise;
   logic prev_locked = 1'b0;
   logic e_v = 1'b0;
   logic [9:0] e_x = '0, e_y = '0;
   logic [7:0] e_rgb = '0;
   logic [15:0] crc_acc = 16'hFFFF, crc_prev = 16'hFFFF;
   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
      for (int i = 7; i >= 0; i--) c = (c[15] ^ d[i]) ? {c[14:0], 1'b0} ^ 16'h1021 : {c[14:0], 1'b0};
      return c;
   endfunction
   function automatic logic [7:0] pix_of(input int hc, input int vc);
      logic [9:0] h, v;
      h = 10'(hc);
      v = 10'(vc);
      return {h[2:0], v[2:0], h[4:3]};
   endfunction
   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   // outputs sampled at the end of a step reflect the inputs of the previous step
   task automatic step(input logic hs, input logic vs, input int hc, input int vc, input logic [7:0] rgb);
      logic v;
      hsync = hs;
      vsync = vs;
      red   = rgb[7:5];
      green = rgb[4:2];
      blue  = {~rgb[0], rgb[1:0]};
      v = hc >= HB && hc < HF && vc >= VB && vc < VF;
      @(negedge dclk);
      n++;
      if (pmode == 1 && (pix_valid !== e_v || pix_x !== e_x || pix_y !== e_y || pix_rgb !== e_rgb)) pix_bad++;
      if (pmode == 0 && {pix_valid, pix_x, pix_y, pix_rgb} !== 29'd0) pix_bad++;
      if (pix_valid === 1'b1 && first_valid < 0) first_valid = n;
      if (err_hline === 1'b1) n_eh++;
      if (err_vframe === 1'b1) n_ev++;
      if (frame_start === 1'b1) begin
         n_fs++;
         last_fs = n;
      end
      if (locked === 1'b1 && !prev_locked) last_rise = n;
      prev_locked = locked === 1'b1;
`ifdef VGA_RX_CRC_EN
      if (frame_crc_valid === 1'b1) begin
         n_crcv++;
         check("frame_crc", frame_crc, crc_prev);
      end
`endif
      if (pmode == 1 && v) crc_acc = crc_upd(crc_acc, rgb);
      e_v   = v;
      e_x   = v ? 10'(hc - HB) : 10'd0;
      e_y   = v ? 10'(vc - VB) : 10'd0;
      e_rgb = v ? rgb : 8'd0;
   endtask
   task automatic run_frame(input int idx, input frame_t f);
      n_eh = 0; n_ev = 0; n_fs = 0; n_crcv = 0; pix_bad = 0;
      first_valid = -1; mark = -1; last_fs = -100; last_rise = -100;
      crc_prev = crc_acc;
      crc_acc = 16'hFFFF;
      pmode = f.pmode;
      for (int vc = 0; vc < f.lines; vc++)
         for (int hc = 0; hc < (vc == f.short_ln ? HP - 1 : HP); hc++) begin
            rst = vc == f.rst_ln && hc == HB + 5;
            step(hc >= (vc == f.narrow_ln ? HW - 1 : HW), vc >= VW, hc, vc, pix_of(hc, vc));
            if (vc == VB && hc == HB) mark = n;
            if (rst) begin
               check($sformatf("f%0d rst_outputs_zero", idx),
                     {pix_x, pix_y, pix_rgb, pix_valid, frame_start, locked, err_hline, err_vframe, err_count}, 0);
`ifdef VGA_RX_CRC_EN
               check($sformatf("f%0d rst_crc_zero", idx), {frame_crc, frame_crc_valid}, 0);
`endif
               rst = 1'b0;
            end
         end
      check($sformatf("f%0d err_hline_pulses", idx), n_eh, f.eh);
      check($sformatf("f%0d err_vframe_pulses", idx), n_ev, f.ev);
      check($sformatf("f%0d frame_start_pulses", idx), n_fs, 1);
      check($sformatf("f%0d locked_end", idx), locked, f.lock_end);
      check($sformatf("f%0d err_count", idx), err_count, f.ecnt);
      if (f.pmode != 2) check($sformatf("f%0d pixel_mismatches", idx), pix_bad, 0);
`ifdef VGA_RX_CRC_EN
      check($sformatf("f%0d crc_valid_pulses", idx), n_crcv, f.crcv);
`endif
   endtask
   initial begin
      // lines, short, narrow, rst line, pix mode (0 zero / 1 locked / 2 skip), eh, ev, crcv, locked, err_count
      tbl[0]  = '{VL, -1, -1, -1, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{VL, -1, -1, -1, 0, 0, 0, 0, 0, 0};
      tbl[2]  = '{VL, -1, -1, -1, 1, 0, 0, 0, 1, 0};
      tbl[3]  = '{VL,  5, -1, -1, 2, 1, 0, 1, 0, 1};
      tbl[4]  = '{VL, -1, -1, -1, 0, 0, 0, 0, 0, 1};
      tbl[5]  = '{VL, -1, -1, -1, 0, 0, 0, 0, 0, 1};
      tbl[6]  = '{VL, -1, -1, -1, 1, 0, 0, 0, 1, 1};
      tbl[7]  = '{VL, -1,  4, -1, 2, 1, 0, 1, 0, 2};
      tbl[8]  = '{VL - 1, -1, -1, -1, 0, 0, 0, 0, 0, 2};
      tbl[9]  = '{VL, -1, -1, -1, 0, 0, 1, 0, 0, 3};
      tbl[10] = '{VL, -1, -1, -1, 0, 0, 0, 0, 0, 3};
      tbl[11] = '{VL, -1, -1, -1, 1, 0, 0, 0, 1, 3};
      tbl[12] = '{VL, -1, -1,  5, 2, 0, 0, 1, 0, 0};
      tbl[13] = '{VL, -1, -1, -1, 0, 0, 0, 0, 0, 0};
      tbl[14] = '{VL, -1, -1, -1, 0, 0, 0, 0, 0, 0};
      tbl[15] = '{VL, -1, -1, -1, 1, 0, 0, 0, 1, 0};
      tbl[16] = '{VL, -1, -1, -1, 1, 0, 0, 1, 1, 0};
      rst = 1'b1;
      pix_bad = 0;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 0, 0, 8'h00);
      check("reset_outputs_zero",
            {pix_x, pix_y, pix_rgb, pix_valid, frame_start, locked, err_hline, err_vframe, err_count}, 0);
      rst = 1'b0;
      for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 0, 0, 8'h00);
      check("idle_pixel_mismatches", pix_bad, 0);
      for (int i = 0; i < 17; i++) begin
         run_frame(i, tbl[i]);
         if (i == 2) begin
            check("f2 lock_after_frame_start", last_rise - last_fs, 1);
            check("f2 first_valid_latency", first_valid - mark, 1);
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
